// File: rtl/mul_server_pkg.sv
// Shared types for the mul_server block: operand/product widths, the
// pipeline stage record and the product helper.
package mul_server_pkg;

    localparam int MUL_A_W   = 53;
    localparam int MUL_B_W   = 27;
    localparam int MUL_P_W   = 80;
    // Port ids cover up to 8 requesters; tags up to 16 bits are carried.
    localparam int PORT_ID_W = 3;
    localparam int TAG_MAX_W = 16;

    typedef logic [MUL_A_W-1:0] mul_a_t;
    typedef logic [MUL_B_W-1:0] mul_b_t;
    typedef logic [MUL_P_W-1:0] mul_p_t;

    typedef struct packed {
        logic                 valid;
        logic [PORT_ID_W-1:0] port;
        logic [TAG_MAX_W-1:0] tag;
        mul_p_t               prod;
    } mul_stage_t;

    // Unsigned full-width product, zero-extended operands.
    function automatic mul_p_t mul_prod(input mul_a_t a, input mul_b_t b);
        return MUL_P_W'(a) * MUL_P_W'(b);
    endfunction

endpackage

// File: rtl/mul_server_if.sv
// Request/response bundle between the requesters (master) and the shared
// multiplier server (slave). Port i occupies slice i of every vector.
interface mul_server_if
    import mul_server_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int TAG_W = 4
);
    logic [NPORT-1:0]         req_valid;
    logic [NPORT-1:0]         req_ready;
    logic [NPORT*MUL_A_W-1:0] req_a;
    logic [NPORT*MUL_B_W-1:0] req_b;
    logic [NPORT*TAG_W-1:0]   req_tag;
    logic [NPORT-1:0]         rsp_valid;
    logic [NPORT-1:0]         rsp_ready;
    logic [NPORT*MUL_P_W-1:0] rsp_data;
    logic [NPORT*TAG_W-1:0]   rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/mul_server_fifo.sv
// Per-port response FIFO: circular buffer with wrap-around pointers and an
// occupancy count. Push and pop in the same cycle are both honoured.
module mul_server_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 84
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count == '0);
    // Head reads as zero while empty so nothing stale leaks to the port.
    assign head  = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mul_server.sv
// Shared multiplier server: round-robin arbitration over NPORT requesters,
// a fixed-latency product pipeline, and per-port in-order response FIFOs
// protected by credit counters. Optional build macro MUL_SERVER_STATS_EN
// adds saturating accept-per-port and busy-cycle counters.
module mul_server
    import mul_server_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int LAT   = 3,
    parameter int OSTD  = 4,
    parameter int TAG_W = 4     // must not exceed TAG_MAX_W
) (
    input  logic              clk,
    input  logic              reset,
    mul_server_if.slave       bus
`ifdef MUL_SERVER_STATS_EN
    ,
    output logic [NPORT*32-1:0] stat_grant,
    output logic [31:0]         stat_busy
`endif
);
    localparam int RR_W  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CNT_W = $clog2(OSTD + 1);
    localparam int ENT_W = TAG_W + MUL_P_W;

    logic [RR_W-1:0]                  rr;
    logic [NPORT-1:0]                 elig;
    logic [NPORT-1:0]                 grant;
    logic [PORT_ID_W-1:0]             gid;
    logic [NPORT-1:0][CNT_W-1:0]      cnt;
    logic [NPORT-1:0]                 push;
    logic [NPORT-1:0]                 pop;
    logic [NPORT-1:0]                 empty;
    logic [NPORT-1:0][ENT_W-1:0]      fifo_head;
    logic [NPORT-1:0][MUL_P_W-1:0]    rsp_data_p;
    logic [NPORT-1:0][TAG_W-1:0]      rsp_tag_p;
    logic [LAT-1:0]                   vld_pipe;
    mul_stage_t                       st0;
    mul_stage_t                       wb;

    // A port may compete only while it has a free credit; nothing is
    // granted during reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++)
            elig[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(OSTD)) && !reset;
    end

    // Round-robin pick: first eligible port starting at rr.
    always_comb begin
        grant = '0;
        gid   = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (grant == '0 && elig[(int'(rr) + k) % NPORT]) begin
                grant[(int'(rr) + k) % NPORT] = 1'b1;
                gid = PORT_ID_W'((int'(rr) + k) % NPORT);
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (reset)       rr <= '0;
        else if (|grant) rr <= RR_W'((int'(gid) + 1) % NPORT);
    end

    // Issue stage: operands are sampled only for the granted port.
    always_comb begin
        st0 = '0;
        if (|grant) begin
            st0.valid = 1'b1;
            st0.port  = gid;
            st0.tag   = TAG_MAX_W'(bus.req_tag[int'(gid)*TAG_W +: TAG_W]);
            st0.prod  = mul_prod(bus.req_a[int'(gid)*MUL_A_W +: MUL_A_W],
                                 bus.req_b[int'(gid)*MUL_B_W +: MUL_B_W]);
        end
    end

    assign vld_pipe[0] = st0.valid;

    generate
        if (LAT > 1) begin : g_pipe
            mul_stage_t pipe [1:LAT-1];

            // Delay line; only the valid bits need reset, the product
            // registers are free to retime into the multiplier.
            always_ff @(posedge clk) begin
                pipe[1] <= st0;
                for (int k = 2; k < LAT; k++) pipe[k] <= pipe[k-1];
                if (reset)
                    for (int k = 1; k < LAT; k++) pipe[k].valid <= 1'b0;
            end

            for (genvar k = 1; k < LAT; k++) begin : g_vld
                assign vld_pipe[k] = pipe[k].valid;
            end

            assign wb = pipe[LAT-1];
        end else begin : g_direct
            assign wb = st0;
        end
    endgenerate

    // Route the finishing product to its owner's FIFO.
    always_comb begin
        push = '0;
        for (int i = 0; i < NPORT; i++)
            push[i] = wb.valid && (wb.port == PORT_ID_W'(i));
    end

    assign pop = bus.rsp_ready & ~empty & {NPORT{~reset}};

    // Credits: accept adds one, pop returns one, both together cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                case ({grant[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar i = 0; i < NPORT; i++) begin : g_port
            mul_server_fifo #(.DEPTH(OSTD), .WIDTH(ENT_W)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[i]),
                .din   ({wb.tag[TAG_W-1:0], wb.prod}),
                .pop   (pop[i]),
                .empty (empty[i]),
                .head  (fifo_head[i])
            );
            assign rsp_tag_p[i]  = fifo_head[i][MUL_P_W +: TAG_W];
            assign rsp_data_p[i] = fifo_head[i][MUL_P_W-1:0];
        end
    endgenerate

    assign bus.req_ready = grant;
    assign bus.rsp_valid = reset ? '0 : ~empty;
    assign bus.rsp_data  = reset ? '0 : rsp_data_p;
    assign bus.rsp_tag   = reset ? '0 : rsp_tag_p;

`ifdef MUL_SERVER_STATS_EN
    logic [NPORT-1:0][31:0] grant_cnt;

    // Saturating accept counters per port and multiplier-busy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            stat_busy <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++)
                if (grant[i] && grant_cnt[i] != '1)
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
            if ((|vld_pipe) && stat_busy != '1)
                stat_busy <= stat_busy + 32'd1;
        end
    end

    assign stat_grant = grant_cnt;

    logic unused_bits;
    assign unused_bits = ^wb.tag;
`else
    logic unused_bits;
    assign unused_bits = ^{wb.tag, vld_pipe};
`endif
endmodule

// File: tb/tb_mul_server.sv
// Directed bench for mul_server (NPORT=2, LAT=3, OSTD=4, TAG_W=4) with a
// per-port response scoreboard.
module tb_mul_server;
    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    mul_server_if #(.NPORT(2), .TAG_W(4)) bus ();

`ifdef MUL_SERVER_STATS_EN
    logic [63:0] stat_grant;
    logic [31:0] stat_busy;
`endif

    mul_server #(.NPORT(2), .LAT(3), .OSTD(4), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MUL_SERVER_STATS_EN
        ,
        .stat_grant (stat_grant),
        .stat_busy  (stat_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [83:0] obs, input logic [83:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int p, input logic [52:0] a, input logic [26:0] b,
                          input logic [3:0] tag);
        bus.req_a[p*53 +: 53] = a;
        bus.req_b[p*27 +: 27] = b;
        bus.req_tag[p*4 +: 4] = tag;
    endtask

    // Scoreboard: expected {tag, product} per port in issue order.
    logic [83:0] exp_q [2][$];
    int acc_cnt [2] = '{0, 0};
    int rsp_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) exp_q[p].delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.rsp_valid[p] && bus.rsp_ready[p]) begin
                    rsp_cnt[p]++;
                    chk("rsp_pending", 84'(exp_q[p].size() != 0), 84'(1));
                    if (exp_q[p].size() != 0)
                        chk("rsp_tag_data", {bus.rsp_tag[p*4 +: 4], bus.rsp_data[p*80 +: 80]},
                            exp_q[p].pop_front());
                end
                if (bus.req_valid[p] && bus.req_ready[p]) begin
                    acc_cnt[p]++;
                    exp_q[p].push_back({bus.req_tag[p*4 +: 4],
                                        80'(bus.req_a[p*53 +: 53]) * 80'(bus.req_b[p*27 +: 27])});
                end
            end
        end
    end

    task automatic drain(input string name);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (8) tick();
        chk({name, "_q0"}, 84'(exp_q[0].size()), 84'(0));
        chk({name, "_q1"}, 84'(exp_q[1].size()), 84'(0));
        chk({name, "_cnt0"}, 84'(rsp_cnt[0]), 84'(acc_cnt[0]));
        chk({name, "_cnt1"}, 84'(rsp_cnt[1]), 84'(acc_cnt[1]));
        @(negedge clk);
        chk({name, "_rsp_valid"}, 84'(bus.rsp_valid), 84'(0));
        tick();
    endtask

    int a0;
    int r0;
    int r1;
    int total;

    initial begin
        reset         = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 2'b00;

        // Reset: outputs held quiet even with requests pending.
        @(negedge clk);
        chk("reset_req_ready", 84'(bus.req_ready), 84'(0));
        chk("reset_rsp_valid", 84'(bus.rsp_valid), 84'(0));
        chk("reset_rsp_data", 84'(bus.rsp_data != '0), 84'(0));
        chk("reset_rsp_tag", 84'(bus.rsp_tag), 84'(0));
        tick();
        tick();
        reset         = 1'b0;
        bus.req_valid = 2'b00;

        // Single op: 3*5, tag 2, visible exactly LAT cycles after accept.
        set_op(0, 53'd3, 27'd5, 4'd2);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("single_grant", 84'(bus.req_ready), 84'(2'b01));
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("single_lat1", 84'(bus.rsp_valid), 84'(0));
        tick();
        @(negedge clk);
        chk("single_lat2", 84'(bus.rsp_valid), 84'(0));
        tick();
        @(negedge clk);
        chk("single_valid", 84'(bus.rsp_valid), 84'(2'b01));
        chk("single_data", 84'(bus.rsp_data[79:0]), 84'h0F);
        chk("single_tag", 84'(bus.rsp_tag[3:0]), 84'd2);
        tick();
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        chk("single_popped", 84'(bus.rsp_valid), 84'(0));
        tick();

        // Max operands.
        set_op(0, 53'h1F_FFFF_FFFF_FFFF, 27'h7FF_FFFF, 4'hA);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        @(negedge clk);
        chk("max_data", 84'(bus.rsp_data[79:0]), 84'(80'hFFFF_FFDF_FFFF_F800_0001));
        chk("max_tag", 84'(bus.rsp_tag[3:0]), 84'hA);
        tick();
        drain("max_drain");

        // Round robin: rr points at port 1 after the two port-0 grants.
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            set_op(0, 53'(1000 + i), 27'(i + 1), 4'(i));
            set_op(1, 53'(2000 + i), 27'(i + 3), 4'(i + 8));
            @(negedge clk);
            chk("rr_grant", 84'(bus.req_ready), (i % 2 == 0) ? 84'(2'b10) : 84'(2'b01));
            tick();
        end
        drain("rr_drain");

        // Credit full: port 0 never popped, gets exactly OSTD accepts.
        a0 = acc_cnt[0];
        set_op(0, 53'd11, 27'd13, 4'd1);
        set_op(1, 53'd17, 27'd19, 4'd3);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b10;
        repeat (12) tick();
        chk("credit_accepts", 84'(acc_cnt[0] - a0), 84'(4));
        @(negedge clk);
        chk("credit_port1_only", 84'(bus.req_ready), 84'(2'b10));
        tick();
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        chk("credit_pop_cycle", 84'(bus.req_ready), 84'(2'b00));
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        chk("credit_one_more", 84'(bus.req_ready), 84'(2'b01));
        tick();
        @(negedge clk);
        chk("credit_full_again", 84'(bus.req_ready), 84'(2'b00));
        tick();
        chk("credit_total", 84'(acc_cnt[0] - a0), 84'(5));
        drain("credit_drain");

        // Accept and pop together at cnt = OSTD-1 leaves cnt unchanged.
        set_op(0, 53'd21, 27'd23, 4'd6);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        repeat (3) tick();
        bus.req_valid = 2'b00;
        repeat (3) tick();
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        chk("simul_accept", 84'(bus.req_ready), 84'(2'b01));
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        chk("simul_cnt_held", 84'(bus.req_ready), 84'(2'b01));
        tick();
        @(negedge clk);
        chk("simul_now_full", 84'(bus.req_ready), 84'(2'b00));
        tick();
        drain("simul_drain");

        // Random traffic, scoreboard checks every response.
        total = 0;
        for (int c = 0; c < 1500 && total < 100; c++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.rsp_ready = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++)
                set_op(p, 53'({$urandom(), $urandom()}), 27'($urandom()), 4'($urandom()));
            @(negedge clk);
            total = total + int'(bus.req_valid[0] & bus.req_ready[0])
                          + int'(bus.req_valid[1] & bus.req_ready[1]);
            tick();
        end
        chk("rand_ops", 84'(total >= 100), 84'(1));
        drain("rand_drain");

        // Reset mid-flight: last pre-reset grant is port 0, so rr sits at 1.
        set_op(0, 53'd31, 27'd37, 4'd4);
        set_op(1, 53'd41, 27'd43, 4'd9);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b11;
        repeat (3) tick();
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b11;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 84'(bus.req_ready), 84'(0));
        chk("midrst_rsp_valid", 84'(bus.rsp_valid), 84'(0));
        chk("midrst_rsp_data", 84'(bus.rsp_data != '0), 84'(0));
        tick();
        reset = 1'b0;
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        acc_cnt[0] = rsp_cnt[0];
        acc_cnt[1] = rsp_cnt[1];
        set_op(0, 53'd7, 27'd9, 4'd5);
        @(negedge clk);
        chk("postrst_rsp_valid", 84'(bus.rsp_valid), 84'(0));
        chk("postrst_rr0", 84'(bus.req_ready), 84'(2'b01));
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        @(negedge clk);
        chk("postrst_data", 84'(bus.rsp_data[79:0]), 84'd63);
        chk("postrst_valid", 84'(bus.rsp_valid), 84'(2'b01));
        tick();
        drain("postrst_drain");
        chk("postrst_rsp0", 84'(rsp_cnt[0] - r0), 84'(1));
        chk("postrst_rsp1", 84'(rsp_cnt[1] - r1), 84'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
